// File: rtl/demux_fifo_1to2.sv
// demux_fifo_1to2: routes each accepted input word into one of two
// independent DEPTH-entry FIFOs (A when sel_in=1, B when sel_in=0).
// Each FIFO drains through its own valid/ready handshake.
module demux_fifo_1to2 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    input  logic                     sel_in,
    output logic                     ready_out,
    output logic [WIDTH-1:0]         a_data_out,
    output logic                     a_valid_out,
    input  logic                     a_ready_in,
    output logic [$clog2(DEPTH):0]   a_count_out,
    output logic [WIDTH-1:0]         b_data_out,
    output logic                     b_valid_out,
    input  logic                     b_ready_in,
    output logic [$clog2(DEPTH):0]   b_count_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Channel 0 is FIFO A, channel 1 is FIFO B.
    logic [1:0]       push;
    logic [1:0]       pop_ready;
    logic [1:0]       head_valid;
    logic [WIDTH-1:0] head_data [2];
    logic [CW-1:0]    count     [2];

    // Acceptance depends only on the selected FIFO's registered occupancy,
    // so a full FIFO never passes a word through on a same-cycle pop.
    assign ready_out = sel_in ? (count[0] != CW'(DEPTH))
                              : (count[1] != CW'(DEPTH));

    assign push[0]   = valid_in & ready_out & sel_in;
    assign push[1]   = valid_in & ready_out & ~sel_in;
    assign pop_ready = {b_ready_in, a_ready_in};

    for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt_q;
        logic             pop;

        assign pop = head_valid[ch] & pop_ready[ch];

        // Pointer and occupancy update; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[ch]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push[ch], pop})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        // Storage write; contents are don't-care until covered by the count.
        always_ff @(posedge clk_in) begin
            if (push[ch]) begin
                mem[wr_ptr] <= data_in;
            end
        end

        assign head_valid[ch] = (cnt_q != '0);
        assign head_data[ch]  = head_valid[ch] ? mem[rd_ptr] : '0;
        assign count[ch]      = cnt_q;
    end

    assign a_data_out  = head_data[0];
    assign a_valid_out = head_valid[0];
    assign a_count_out = count[0];
    assign b_data_out  = head_data[1];
    assign b_valid_out = head_valid[1];
    assign b_count_out = count[1];

endmodule

// File: tb/tb_demux_fifo_1to2.sv
// Bench for demux_fifo_1to2: a negedge monitor keeps an occupancy model and
// per-output expectation queues; scenario tasks add targeted checks.
module tb_demux_fifo_1to2;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_in = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid_in = 1'b0;
    logic             sel_in = 1'b0;
    logic             ready_out;
    logic [WIDTH-1:0] a_data_out;
    logic             a_valid_out;
    logic             a_ready_in = 1'b1;
    logic [CW-1:0]    a_count_out;
    logic [WIDTH-1:0] b_data_out;
    logic             b_valid_out;
    logic             b_ready_in = 1'b1;
    logic [CW-1:0]    b_count_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit               mon_en = 1'b0;
    bit               acc = 1'b0;
    int               m_cnt_a = 0;
    int               m_cnt_b = 0;
    int               rx_a = 0;
    int               rx_b = 0;
    logic [WIDTH-1:0] exp_a [$];
    logic [WIDTH-1:0] exp_b [$];
    logic [WIDTH-1:0] e;
    bit               m_ready, push_a, push_b, pop_a, pop_b;

    demux_fifo_1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .sel_in      (sel_in),
        .ready_out   (ready_out),
        .a_data_out  (a_data_out),
        .a_valid_out (a_valid_out),
        .a_ready_in  (a_ready_in),
        .a_count_out (a_count_out),
        .b_data_out  (b_data_out),
        .b_valid_out (b_valid_out),
        .b_ready_in  (b_ready_in),
        .b_count_out (b_count_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: check state, pop expected words, push accepted words
    always @(negedge clk) begin
        if (mon_en) begin
            m_ready = sel_in ? (m_cnt_a != DEPTH) : (m_cnt_b != DEPTH);
            total++;
            if (ready_out !== m_ready) begin
                bad++; $display("FAIL mon_ready got=%0b exp=%0b t=%0t", ready_out, m_ready, $time);
            end
            total++;
            if (a_count_out !== CW'(m_cnt_a) || a_valid_out !== (m_cnt_a != 0)) begin
                bad++; $display("FAIL mon_a_state cnt=%0d valid=%0b exp_cnt=%0d t=%0t", a_count_out, a_valid_out, m_cnt_a, $time);
            end
            total++;
            if (b_count_out !== CW'(m_cnt_b) || b_valid_out !== (m_cnt_b != 0)) begin
                bad++; $display("FAIL mon_b_state cnt=%0d valid=%0b exp_cnt=%0d t=%0t", b_count_out, b_valid_out, m_cnt_b, $time);
            end
            if (m_cnt_a == 0) begin
                total++;
                if (a_data_out !== '0) begin
                    bad++; $display("FAIL mon_a_empty_data got=%h exp=00 t=%0t", a_data_out, $time);
                end
            end
            if (m_cnt_b == 0) begin
                total++;
                if (b_data_out !== '0) begin
                    bad++; $display("FAIL mon_b_empty_data got=%h exp=00 t=%0t", b_data_out, $time);
                end
            end
            if (rst_in) begin
                exp_a.delete();
                exp_b.delete();
                m_cnt_a = 0;
                m_cnt_b = 0;
                acc = 1'b0;
            end else begin
                pop_a  = (m_cnt_a != 0) && a_ready_in;
                pop_b  = (m_cnt_b != 0) && b_ready_in;
                push_a = valid_in && m_ready && sel_in;
                push_b = valid_in && m_ready && !sel_in;
                if (pop_a) begin
                    e = (exp_a.size() > 0) ? exp_a.pop_front() : 'x;
                    total++; rx_a++;
                    if (a_data_out !== e) begin
                        bad++; $display("FAIL mon_a_data got=%h exp=%h t=%0t", a_data_out, e, $time);
                    end
                end
                if (pop_b) begin
                    e = (exp_b.size() > 0) ? exp_b.pop_front() : 'x;
                    total++; rx_b++;
                    if (b_data_out !== e) begin
                        bad++; $display("FAIL mon_b_data got=%h exp=%h t=%0t", b_data_out, e, $time);
                    end
                end
                if (push_a) exp_a.push_back(data_in);
                if (push_b) exp_b.push_back(data_in);
                m_cnt_a = m_cnt_a + int'(push_a) - int'(pop_a);
                m_cnt_b = m_cnt_b + int'(push_b) - int'(pop_b);
                acc = push_a || push_b;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the model says it was taken
    task automatic send(input logic [WIDTH-1:0] d, input logic s);
        int n = 0;
        data_in  = d;
        sel_in   = s;
        valid_in = 1'b1;
        do begin
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout data=%h sel=%0b got=stuck exp=accepted", d, s);
        end
    endtask

    task automatic idle();
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_cnt_a != 0 || m_cnt_b != 0) && n < 100) begin
            step();
            n++;
        end
        total++;
        if (a_count_out !== '0 || b_count_out !== '0) begin
            bad++; $display("FAIL drain a_cnt=%0d b_cnt=%0d exp=0/0", a_count_out, b_count_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b1; sel_in = 1'b1; data_in = 8'h5A;
        step();
        mon_en = 1'b1;
        step();
        total++;
        if (a_count_out !== '0 || b_count_out !== '0 || a_valid_out !== 1'b0 || b_valid_out !== 1'b0) begin
            bad++; $display("FAIL reset_state a=%0d/%0b b=%0d/%0b exp=0/0", a_count_out, a_valid_out, b_count_out, b_valid_out);
        end
        total++;
        if (a_data_out !== '0 || b_data_out !== '0 || ready_out !== 1'b1) begin
            bad++; $display("FAIL reset_outs a=%h b=%h rdy=%0b exp=00 00 1", a_data_out, b_data_out, ready_out);
        end
        rst_in = 1'b0; valid_in = 1'b0;
        step();
        total++;
        if (a_valid_out !== 1'b0 || b_valid_out !== 1'b0) begin
            bad++; $display("FAIL reset_release a_valid=%0b b_valid=%0b exp=0 0", a_valid_out, b_valid_out);
        end
    endtask

    task automatic test_routing();
        a_ready_in = 1'b1; b_ready_in = 1'b1;
        send(8'h11, 1'b1);
        total++;
        if (a_valid_out !== 1'b1 || a_data_out !== 8'h11 || b_valid_out !== 1'b0) begin
            bad++; $display("FAIL route_a1 got=%0b/%h b_valid=%0b exp=1/11 0", a_valid_out, a_data_out, b_valid_out);
        end
        send(8'h22, 1'b0);
        total++;
        if (b_valid_out !== 1'b1 || b_data_out !== 8'h22 || a_valid_out !== 1'b0) begin
            bad++; $display("FAIL route_b got=%0b/%h a_valid=%0b exp=1/22 0", b_valid_out, b_data_out, a_valid_out);
        end
        send(8'h33, 1'b1);
        idle();
        total++;
        if (a_valid_out !== 1'b1 || a_data_out !== 8'h33 || b_valid_out !== 1'b0) begin
            bad++; $display("FAIL route_a2 got=%0b/%h b_valid=%0b exp=1/33 0", a_valid_out, a_data_out, b_valid_out);
        end
        step();
        total++;
        if (a_valid_out !== 1'b0) begin
            bad++; $display("FAIL route_empty a_valid=%0b exp=0", a_valid_out);
        end
    endtask

    task automatic test_full_a();
        a_ready_in = 1'b0; b_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1);
        total++;
        if (a_count_out !== CW'(4)) begin
            bad++; $display("FAIL full_a_count got=%0d exp=4", a_count_out);
        end
        data_in = 8'hA4; sel_in = 1'b1; valid_in = 1'b1;
        #1;
        total++;
        if (ready_out !== 1'b0) begin
            bad++; $display("FAIL full_a_ready got=%0b exp=0", ready_out);
        end
        step();
        total++;
        if (a_count_out !== CW'(4) || acc) begin
            bad++; $display("FAIL full_a_hold cnt=%0d acc=%0b exp=4 0", a_count_out, acc);
        end
        sel_in = 1'b0;
        #1;
        total++;
        if (ready_out !== 1'b1) begin
            bad++; $display("FAIL full_a_switch_ready got=%0b exp=1", ready_out);
        end
        step();
        idle();
        total++;
        if (b_count_out !== CW'(1) || b_data_out !== 8'hA4) begin
            bad++; $display("FAIL full_a_to_b cnt=%0d data=%h exp=1 a4", b_count_out, b_data_out);
        end
    endtask

    task automatic test_full_pop();
        data_in = 8'hB0; sel_in = 1'b1; valid_in = 1'b1;
        a_ready_in = 1'b1; b_ready_in = 1'b1;
        #1;
        total++;
        if (ready_out !== 1'b0) begin
            bad++; $display("FAIL fullpop_ready got=%0b exp=0", ready_out);
        end
        step();
        total++;
        if (a_count_out !== CW'(3) || acc) begin
            bad++; $display("FAIL fullpop_first cnt=%0d acc=%0b exp=3 0", a_count_out, acc);
        end
        step();
        idle();
        total++;
        if (a_count_out !== CW'(3) || !acc) begin
            bad++; $display("FAIL fullpop_second cnt=%0d acc=%0b exp=3 1", a_count_out, acc);
        end
        drain();
    endtask

    task automatic test_wrap();
        int base = rx_b;
        a_ready_in = 1'b1; b_ready_in = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
                idle();
            end
            begin
                for (int k = 0; k < 70; k++) begin
                    step();
                    b_ready_in = ~b_ready_in;
                    if (b_count_out > CW'(4)) begin
                        total++; bad++;
                        $display("FAIL wrap_overflow cnt=%0d exp<=4", b_count_out);
                    end
                end
            end
        join
        b_ready_in = 1'b1;
        drain();
        total++;
        if (rx_b - base != 20) begin
            bad++; $display("FAIL wrap_received got=%0d exp=20", rx_b - base);
        end
    endtask

    task automatic test_reset_mid();
        a_ready_in = 1'b0; b_ready_in = 1'b0;
        send(8'hC1, 1'b1); send(8'hC2, 1'b1); send(8'hC3, 1'b1);
        send(8'hD1, 1'b0); send(8'hD2, 1'b0);
        idle();
        total++;
        if (a_count_out !== CW'(3) || b_count_out !== CW'(2)) begin
            bad++; $display("FAIL mid_fill a=%0d b=%0d exp=3 2", a_count_out, b_count_out);
        end
        rst_in = 1'b1; a_ready_in = 1'b1; b_ready_in = 1'b1;
        step();
        rst_in = 1'b0;
        total++;
        if (a_count_out !== '0 || b_count_out !== '0 || a_valid_out !== 1'b0 || b_data_out !== '0) begin
            bad++; $display("FAIL mid_reset a=%0d b=%0d a_valid=%0b b_data=%h exp=0 0 0 00", a_count_out, b_count_out, a_valid_out, b_data_out);
        end
        a_ready_in = 1'b0;
        send(8'hA5, 1'b1);
        idle();
        total++;
        if (a_data_out !== 8'hA5 || a_count_out !== CW'(1) || b_valid_out !== 1'b0) begin
            bad++; $display("FAIL mid_new data=%h cnt=%0d b_valid=%0b exp=a5 1 0", a_data_out, a_count_out, b_valid_out);
        end
        a_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (a_valid_out !== 1'b0 || b_valid_out !== 1'b0) begin
                bad++; $display("FAIL mid_stale a_valid=%0b b_valid=%0b exp=0 0", a_valid_out, b_valid_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full_a();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
